// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the fetch path: word width, NOP encoding,
// default reset vector and the {pc, instr} entry held in the fetch buffer.
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam int FIFO_DEPTH_DEFAULT = 2;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t NOP_INSTR        = 32'h0000_0013;
    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    function automatic word_t align_word(input word_t addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit
// (master) and the instruction memory (slave).
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic  imem_req_valid;
    logic  imem_req_ready;
    word_t imem_req_addr;
    logic  imem_rsp_valid;
    word_t imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Two-entry registered {pc, instr} buffer between instruction memory and IF/ID.
// Push and pop may coincide; flush empties it in one cycle.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_entry,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of the entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited request issue, in-order
// response tagging, and dropping of responses that were in flight at a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC   = RESET_PC_DEFAULT,
    parameter int    FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                checkpre_flush,
    input  word_t               redirect_pc,
    input  logic                feedforward_stall,
    fetch_unit_if.master        imem,
    output word_t               instrmem_instr_data,
    output word_t               instr_addr_i,
    output logic                fetch_valid
);

    word_t        pc_q, pc_d;
    logic [1:0]   outstanding_q, outstanding_d;
    logic [1:0]   drop_cnt_q, drop_cnt_d;
    word_t        aq_q [2];
    word_t        aq_d [2];
    logic         aq_rd_q, aq_rd_d;
    logic         aq_wr_q, aq_wr_d;

    logic [1:0]   fifo_count;
    fetch_entry_t fifo_head;
    fetch_entry_t push_entry;
    logic [2:0]   credit_used;
    logic         req_valid;
    logic         req_accept;
    logic         rsp_fire;
    logic         rsp_keep;
    logic         fifo_pop;

    // Credits come from registered counts only, so a full buffer can never
    // be handed another response.
    always_comb begin
        credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
        req_valid   = !rst && !checkpre_flush && (credit_used < 3'(FIFO_DEPTH));
        req_accept  = req_valid && imem.imem_req_ready;
        rsp_fire    = imem.imem_rsp_valid && !rst;
        rsp_keep    = rsp_fire && !checkpre_flush && (drop_cnt_q == 2'd0);
        fetch_valid = !rst && !checkpre_flush && (fifo_count != 2'd0);
        fifo_pop    = fetch_valid && !feedforward_stall;
        push_entry  = '{pc: aq_q[aq_rd_q], instr: imem.imem_rsp_data};
    end

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        aq_d          = aq_q;
        aq_rd_d       = aq_rd_q;
        aq_wr_d       = aq_wr_q;
        if (checkpre_flush) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d          = align_word(redirect_pc);
            outstanding_d = outstanding_q - {1'b0, rsp_fire};
            drop_cnt_d    = outstanding_q - {1'b0, rsp_fire};
            aq_rd_d       = 1'b0;
            aq_wr_d       = 1'b0;
        end else begin
            outstanding_d = outstanding_q + {1'b0, req_accept} - {1'b0, rsp_fire};
            if (req_accept) begin
                aq_d[aq_wr_q] = pc_q;
                aq_wr_d       = ~aq_wr_q;
                pc_d          = pc_q + 32'd4;
            end
            if (rsp_fire) begin
                if (drop_cnt_q != 2'd0) begin
                    drop_cnt_d = drop_cnt_q - 2'd1;
                end else begin
                    aq_rd_d = ~aq_rd_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= 2'd0;
            drop_cnt_q    <= 2'd0;
            aq_rd_q       <= 1'b0;
            aq_wr_q       <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            aq_rd_q       <= aq_rd_d;
            aq_wr_q       <= aq_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        aq_q <= aq_d;
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (checkpre_flush),
        .push       (rsp_keep),
        .pop        (fifo_pop),
        .push_entry (push_entry),
        .count      (fifo_count),
        .head       (fifo_head)
    );

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = rst ? RESET_PC : pc_q;
    assign instrmem_instr_data = fetch_valid ? fifo_head.instr : NOP_INSTR;
    assign instr_addr_i        = fetch_valid ? fifo_head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order memory model drives the
// slave side while a queue-based reference model predicts every output.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam word_t WRAP_PC = 32'hFFFF_FFF8;

    typedef struct packed {
        int    due;
        word_t addr;
    } mem_req_t;

    logic  clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst, checkpre_flush, feedforward_stall, fetch_valid;
    word_t redirect_pc, instrmem_instr_data, instr_addr_i;
    fetch_unit_if bus ();

    logic  rst2, flush2, stall2, fv2;
    word_t redirect2, data2, addr2;
    fetch_unit_if bus2 ();

    fetch_unit #(.RESET_PC(RESET_PC_DEFAULT), .FIFO_DEPTH(2)) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .checkpre_flush      (checkpre_flush),
        .redirect_pc         (redirect_pc),
        .feedforward_stall   (feedforward_stall),
        .imem                (bus.master),
        .instrmem_instr_data (instrmem_instr_data),
        .instr_addr_i        (instr_addr_i),
        .fetch_valid         (fetch_valid)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(2)) u_dut_wrap (
        .clk                 (clk),
        .rst                 (rst2),
        .checkpre_flush      (flush2),
        .redirect_pc         (redirect2),
        .feedforward_stall   (stall2),
        .imem                (bus2.master),
        .instrmem_instr_data (data2),
        .instr_addr_i        (addr2),
        .fetch_valid         (fv2)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int mem_lat      = 1;

    // Reference model state: what the fetch unit should hold, in spec terms.
    word_t        m_pc;
    int           m_out, m_drop;
    fetch_entry_t m_fifo [$];
    word_t        m_aq [$];
    mem_req_t     mem_q [$];

    logic  obs_rv, obs_fv;
    word_t obs_ra, obs_data, obs_addr;

    function automatic word_t mem_data(input word_t a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic model_reset();
        m_pc   = RESET_PC_DEFAULT;
        m_out  = 0;
        m_drop = 0;
        m_fifo.delete();
        m_aq.delete();
    endtask

    // One clock cycle: drive inputs, compare all outputs against the model at
    // the falling edge, then advance memory and model past the rising edge.
    task automatic step(input logic r, input logic fl, input word_t rd,
                        input logic st, input logic rdy, input logic noise);
        logic         rv, exp_rv, exp_fv;
        word_t        rdata, exp_ra, exp_data, exp_addr, tag;
        rst               = r;
        checkpre_flush    = fl;
        redirect_pc       = rd;
        feedforward_stall = st;
        bus.imem_req_ready = rdy;
        rv    = 1'b0;
        rdata = 32'hDEAD_BEEF;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            rv    = 1'b1;
            rdata = mem_data(mem_q[0].addr);
        end
        if (r && noise) begin
            rv    = 1'b1;
            rdata = $urandom;
        end
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = rdata;
        @(negedge clk);
        exp_rv   = !r && !fl && (m_out + m_fifo.size() < 2);
        exp_ra   = r ? RESET_PC_DEFAULT : m_pc;
        exp_fv   = !r && !fl && (m_fifo.size() > 0);
        exp_data = exp_fv ? m_fifo[0].instr : NOP_INSTR;
        exp_addr = exp_fv ? m_fifo[0].pc : 32'h0;
        obs_rv   = bus.imem_req_valid;
        obs_ra   = bus.imem_req_addr;
        obs_fv   = fetch_valid;
        obs_data = instrmem_instr_data;
        obs_addr = instr_addr_i;
        n_compared++;
        if (obs_rv !== exp_rv) begin
            n_mismatched++;
            $display("[TB] FAIL req_valid cyc=%0d got=%0b exp=%0b", cyc, obs_rv, exp_rv);
        end
        n_compared++;
        if (obs_ra !== exp_ra) begin
            n_mismatched++;
            $display("[TB] FAIL req_addr cyc=%0d got=%h exp=%h", cyc, obs_ra, exp_ra);
        end
        n_compared++;
        if (obs_fv !== exp_fv) begin
            n_mismatched++;
            $display("[TB] FAIL fetch_valid cyc=%0d got=%0b exp=%0b", cyc, obs_fv, exp_fv);
        end
        n_compared++;
        if (obs_data !== exp_data) begin
            n_mismatched++;
            $display("[TB] FAIL instr_data cyc=%0d got=%h exp=%h", cyc, obs_data, exp_data);
        end
        n_compared++;
        if (obs_addr !== exp_addr) begin
            n_mismatched++;
            $display("[TB] FAIL instr_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, exp_addr);
        end
        if (!r && rv) begin
            n_compared++;
            if (m_fifo.size() >= 2) begin
                n_mismatched++;
                $display("[TB] FAIL rsp_into_full cyc=%0d fifo=%0d max=1", cyc, m_fifo.size());
            end
        end
        if (r) begin
            mem_q.delete();
        end else begin
            if (rv) void'(mem_q.pop_front());
            if (obs_rv && rdy) mem_q.push_back('{due: cyc + mem_lat, addr: obs_ra});
            n_compared++;
            if (mem_q.size() > 2) begin
                n_mismatched++;
                $display("[TB] FAIL outstanding cyc=%0d got=%0d max=2", cyc, mem_q.size());
            end
        end
        if (r) begin
            model_reset();
        end else if (fl) begin
            if (rv) m_out--;
            m_drop = m_out;
            m_fifo.delete();
            m_aq.delete();
            m_pc = {rd[31:2], 2'b00};
        end else begin
            if (exp_fv && !st) void'(m_fifo.pop_front());
            if (rv) begin
                m_out--;
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    tag = (m_aq.size() > 0) ? m_aq.pop_front() : 32'hBAD0_0000;
                    m_fifo.push_back('{pc: tag, instr: rdata});
                end
            end
            if (exp_rv && rdy) begin
                m_aq.push_back(m_pc);
                m_pc = m_pc + 32'd4;
                m_out++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n, input logic noise);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, noise);
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        mem_lat = 1;
        do_reset(3, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_compared++;
        if (obs_rv !== 1'b1 || obs_ra !== 32'h0 || obs_fv !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset got rv=%0b addr=%h fv=%0b exp rv=1 addr=0 fv=0",
                     obs_rv, obs_ra, obs_fv);
        end
    endtask

    task automatic test_stream();
        word_t req_seen [$];
        word_t fetch_seen [$];
        int    first_fetch;
        word_t exp_pcs [3];
        $display("[TB] test_stream");
        exp_pcs     = '{32'h0, 32'h4, 32'h8};
        first_fetch = -1;
        mem_lat     = 1;
        do_reset(2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            if (obs_rv) req_seen.push_back(obs_ra);
            if (obs_fv) begin
                if (first_fetch < 0) first_fetch = i;
                fetch_seen.push_back(obs_addr);
            end
        end
        n_compared++;
        if (first_fetch !== 2) begin
            n_mismatched++;
            $display("[TB] FAIL first_fetch_cycle got=%0d exp=2", first_fetch);
        end
        for (int i = 0; i < 3; i++) begin
            n_compared++;
            if (req_seen.size() <= i || req_seen[i] !== exp_pcs[i]) begin
                n_mismatched++;
                $display("[TB] FAIL req_order[%0d] got=%h exp=%h", i,
                         (req_seen.size() > i) ? req_seen[i] : 32'hX, exp_pcs[i]);
            end
            n_compared++;
            if (fetch_seen.size() <= i || fetch_seen[i] !== exp_pcs[i]) begin
                n_mismatched++;
                $display("[TB] FAIL fetch_order[%0d] got=%h exp=%h", i,
                         (fetch_seen.size() > i) ? fetch_seen[i] : 32'hX, exp_pcs[i]);
            end
        end
    endtask

    task automatic test_stall();
        word_t after [$];
        word_t exp_after [3];
        int    guard;
        $display("[TB] test_stall");
        exp_after = '{32'h8, 32'hC, 32'h10};
        mem_lat   = 1;
        do_reset(2, 1'b0);
        guard = 0;
        while (!(m_fifo.size() > 0 && m_fifo[0].pc == 32'h8) && guard < 20) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        while (m_fifo.size() < 2 && guard < 30) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            guard++;
        end
        n_compared++;
        if (guard >= 30) begin
            n_mismatched++;
            $display("[TB] FAIL stall_setup got=timeout exp=full_buffer_at_pc8");
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            n_compared++;
            if (obs_rv !== 1'b0 || obs_fv !== 1'b1 || obs_addr !== 32'h8 ||
                obs_data !== mem_data(32'h8)) begin
                n_mismatched++;
                $display("[TB] FAIL stall_hold got rv=%0b fv=%0b pc=%h data=%h exp rv=0 fv=1 pc=8 data=%h",
                         obs_rv, obs_fv, obs_addr, obs_data, mem_data(32'h8));
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            if (obs_fv) after.push_back(obs_addr);
        end
        for (int i = 0; i < 3; i++) begin
            n_compared++;
            if (after.size() <= i || after[i] !== exp_after[i]) begin
                n_mismatched++;
                $display("[TB] FAIL stall_release[%0d] got=%h exp=%h", i,
                         (after.size() > i) ? after[i] : 32'hX, exp_after[i]);
            end
        end
    endtask

    task automatic test_flush();
        int found;
        $display("[TB] test_flush");
        mem_lat = 3;
        do_reset(2, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_compared++;
        if (mem_q.size() != 2) begin
            n_mismatched++;
            $display("[TB] FAIL flush_setup got=%0d outstanding exp=2", mem_q.size());
        end
        step(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b1, 1'b0);
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            if (obs_rv) begin
                found = 1;
                n_compared++;
                if (obs_ra !== 32'h100) begin
                    n_mismatched++;
                    $display("[TB] FAIL redirect_req got=%h exp=00000100", obs_ra);
                end
            end
        end
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            if (obs_fv) begin
                found = 1;
                n_compared++;
                if (obs_addr !== 32'h100 || obs_data !== mem_data(32'h100)) begin
                    n_mismatched++;
                    $display("[TB] FAIL redirect_fetch got pc=%h data=%h exp pc=00000100 data=%h",
                             obs_addr, obs_data, mem_data(32'h100));
                end
            end
        end
        n_compared++;
        if (!found) begin
            n_mismatched++;
            $display("[TB] FAIL redirect_fetch got=timeout exp=fetch_valid");
        end
    endtask

    task automatic test_flush_with_rsp();
        $display("[TB] test_flush_with_rsp");
        mem_lat = 1;
        do_reset(2, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_compared++;
        if (!(mem_q.size() > 0 && mem_q[0].due == cyc)) begin
            n_mismatched++;
            $display("[TB] FAIL flush_rsp_setup got=no_response exp=response_this_cycle");
        end
        step(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b0);
        n_compared++;
        if (obs_fv !== 1'b0 || obs_data !== NOP_INSTR || obs_addr !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL flush_rsp_cycle got fv=%0b data=%h pc=%h exp fv=0 data=00000013 pc=0",
                     obs_fv, obs_data, obs_addr);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        for (int lat = 1; lat <= 3; lat++) begin
            mem_lat = lat;
            do_reset(2, 1'b0);
            for (int i = 0; i < 200; i++) begin
                if (lat == 3 && i == 100) begin
                    do_reset(2, 1'b1);
                end else begin
                    step(1'b0, ($urandom_range(0, 15) == 0), $urandom,
                         ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0);
                end
            end
        end
    endtask

    task automatic test_reset_pc_wrap();
        word_t got_pc [$];
        word_t got_data [$];
        word_t exp_pc [3];
        logic  pend;
        word_t pend_addr;
        $display("[TB] test_reset_pc_wrap");
        exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        rst2 = 1'b1;
        bus2.imem_rsp_valid = 1'b0;
        @(negedge clk);
        n_compared++;
        if (bus2.imem_req_addr !== WRAP_PC || bus2.imem_req_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_reset got addr=%h rv=%0b exp addr=%h rv=0",
                     bus2.imem_req_addr, bus2.imem_req_valid, WRAP_PC);
        end
        @(posedge clk);
        #1;
        rst2      = 1'b0;
        pend      = 1'b0;
        pend_addr = 32'h0;
        for (int i = 0; i < 20 && got_pc.size() < 3; i++) begin
            bus2.imem_rsp_valid = pend;
            bus2.imem_rsp_data  = mem_data(pend_addr);
            @(negedge clk);
            if (fv2) begin
                got_pc.push_back(addr2);
                got_data.push_back(data2);
            end
            pend      = bus2.imem_req_valid;
            pend_addr = bus2.imem_req_addr;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            n_compared++;
            if (got_pc.size() <= i || got_pc[i] !== exp_pc[i] || got_data[i] !== mem_data(exp_pc[i])) begin
                n_mismatched++;
                $display("[TB] FAIL wrap_fetch[%0d] got pc=%h data=%h exp pc=%h data=%h", i,
                         (got_pc.size() > i) ? got_pc[i] : 32'hX,
                         (got_data.size() > i) ? got_data[i] : 32'hX,
                         exp_pc[i], mem_data(exp_pc[i]));
            end
        end
        rst2 = 1'b1;
        bus2.imem_rsp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        checkpre_flush = 1'b0;
        feedforward_stall = 1'b0;
        redirect_pc = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0;
        rst2 = 1'b1;
        flush2 = 1'b0;
        stall2 = 1'b0;
        redirect2 = 32'h0;
        bus2.imem_req_ready = 1'b1;
        bus2.imem_rsp_valid = 1'b0;
        bus2.imem_rsp_data = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_with_rsp();
        test_random();
        test_reset_pc_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
